// File: rtl/fifo_reader_skid.sv
`timescale 1ns/1ps
// fifo_reader_skid
// Circular queue holding words already read from the FIFO but not yet
// accepted by the downstream stream. The storage is cleared on reset, so
// head_data reads 0 while the queue is empty after reset.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   push       write push_data at the tail this cycle
//   push_data  word to write
//   pop        remove the head entry this cycle (ignored when empty)
//   head_data  current head entry, straight from the storage registers
//   cnt        number of occupied entries
module fifo_reader_skid #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3,
  parameter int PTR_W      = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (do_pop) begin
        head <= ptr_inc(head);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_reader.sv
`timescale 1ns/1ps
// fifo_reader
// Drains a FIFO read port into a valid/ready stream. Reads are issued only
// while the local queue plus any in-flight read has room, so rd_en never
// depends on m_ready and the queue can never overflow.
//
// Parameters
//   DATA_WIDTH  width of data_rd / m_data
//   RD_BUFFER   0: data_rd valid in the rd_en cycle, 1: one cycle later
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset (release synchronised upstream)
//   fifo_empty  FIFO empty flag
//   data_rd     FIFO read data
//   rd_en       FIFO read request, one word per high cycle
//   m_data      stream data (queue head)
//   m_valid     stream valid
//   m_ready     stream ready
//   word_cnt    number of completed stream transfers, wraps
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_BUFFER  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int BUF_DEPTH = 2 + RD_BUFFER;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  logic             run;
  logic             infl;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] cnt;
  logic [OCC_W:0]   occ;

  // Holds rd_en low from reset assertion until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign occ   = {1'b0, cnt} + {{OCC_W{1'b0}}, infl};
  assign rd_en = run && !fifo_empty && (occ < (OCC_W + 1)'(BUF_DEPTH));

  generate
    if (RD_BUFFER != 0) begin : g_rd_buffered
      // A read issued in one cycle returns its data during the next one;
      // infl marks that cycle and the word is captured at its closing edge,
      // regardless of what fifo_empty does meanwhile.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          infl <= 1'b0;
        end else begin
          infl <= rd_en;
        end
      end
      assign push = infl;
    end else begin : g_rd_direct
      assign infl = 1'b0;
      assign push = rd_en;
    end
  endgenerate

  assign m_valid = (cnt != '0);
  assign pop     = m_valid && m_ready;

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .PTR_W      (PTR_W),
    .CNT_W      (OCC_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (data_rd),
    .pop       (pop),
    .head_data (m_data),
    .cnt       (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 Parameter RD_BUFFER, default 1; 0 means FIFO data_rd valid in same cycle as rd_en, 1 means valid one cycle after rd_en.
REQ-003 Parameter CNT_WIDTH, default 16, width of delivered-word counter.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fifo_empty  input  1  FIFO empty flag, read side.
REQ-007 data_rd  input  DATA_WIDTH  FIFO read data.
REQ-008 rd_en  output  1  FIFO read request, one word per high cycle.
REQ-009 m_data  output  DATA_WIDTH  stream data.
REQ-010 m_valid  output  1  stream data valid.
REQ-011 m_ready  input  1  downstream ready; transfer when m_valid and m_ready both high at a rising edge.
REQ-012 word_cnt  output  CNT_WIDTH  count of completed stream transfers.

Function
REQ-013 The block SHALL drain the FIFO read interface into a valid/ready stream, preserving word order with no loss or duplication.
REQ-014 Internal buffer depth SHALL be BUF_DEPTH = 2 + RD_BUFFER entries, organised as a circular queue.
REQ-015 rd_en SHALL equal (!fifo_empty) and (cnt + infl < BUF_DEPTH), where cnt is buffered entries and infl is the pending-read flag, both registered; rd_en SHALL NOT depend combinationally on m_ready.
REQ-016 RD_BUFFER=1: infl SHALL be set the cycle after rd_en; data_rd SHALL be written into the queue at the edge ending that cycle.
REQ-017 RD_BUFFER=0: data_rd SHALL be written into the queue at the edge ending the rd_en cycle; infl SHALL be constant 0.
REQ-018 m_valid SHALL be high exactly when cnt > 0; m_data SHALL be the queue head, driven from registers.
REQ-019 First-word latency: fifo_empty falling in cycle T SHALL yield m_valid in cycle T+1+RD_BUFFER.
REQ-020 With m_ready held high and fifo_empty low, the block SHALL sustain one transfer per cycle after the first-word latency.
REQ-021 Simultaneous write and pop in the same cycle SHALL leave cnt unchanged; head and tail pointers SHALL wrap modulo BUF_DEPTH.
REQ-022 When m_ready is low, m_valid and m_data SHALL remain stable until transfer.
REQ-023 With m_ready low, rd_en SHALL stop once cnt + infl reaches BUF_DEPTH; the queue SHALL never overflow.
REQ-024 word_cnt SHALL increment by 1 per transfer and wrap from 2^CNT_WIDTH-1 to 0.
REQ-025 fifo_empty rising while infl=1 SHALL NOT cancel the in-flight word; it SHALL still be captured.

Reset
REQ-026 rst_n low SHALL asynchronously clear rd_en, m_valid, m_data, word_cnt, cnt, infl and queue pointers to 0.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words; after release, rd_en SHALL NOT assert before the first rising edge.
REQ-028 Release of rst_n SHALL be synchronised by the instantiating level; the block SHALL NOT contain a reset synchroniser.

Structure
REQ-029 No shared package; BUF_DEPTH and pointer width (clog2(BUF_DEPTH)) SHALL be localparams.
REQ-030 One sub-module fifo_reader_skid SHALL implement the circular queue (push, pop, head data, cnt); the top holds the rd_en/infl logic and word_cnt.

Verification
REQ-031 RD_BUFFER=1, FIFO preloaded with 12 words 0x01..0x0C, m_ready=1 -> m_data 0x01..0x0C in order, 12 consecutive transfer cycles after 2-cycle latency, word_cnt=12.
REQ-032 RD_BUFFER=0, same preload -> first m_valid 1 cycle after fifo_empty falls, 12 back-to-back transfers.
REQ-033 m_ready=0 with 12 words available -> rd_en high for exactly BUF_DEPTH cycles (3 for RD_BUFFER=1), m_data held at 0x01; m_ready raised -> full order 0x01..0x0C.
REQ-034 Random m_ready (50%) with 200 random words written via async FIFO, wr_clk 20 ns, clk 32 ns -> output sequence equals input sequence, word_cnt=200.
REQ-035 rst_n pulsed low while cnt=2 and infl=1 -> outputs 0 immediately, word_cnt=0, next word read is the next FIFO word.
REQ-036 CNT_WIDTH=4, 17 transfers -> word_cnt wraps and reads 1.
